// File: rtl/ldpc_ber_tester_sched.sv
// Transaction scheduler for the LDPC BER tester: issues CTRL beats under a credit limit,
// tracks issued/finished/in-flight blocks, and runs continuous or fixed-count sessions.
module ldpc_ber_tester_sched #(
    parameter int unsigned MAX_IN_FLIGHT = 16,
    parameter int unsigned IFW           = 8,
    parameter int unsigned CNT_W         = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] target_blocks,
    output logic             ctrl_valid,
    input  logic             ctrl_ready,
    input  logic             status_valid,
    output logic             status_ready,
    input  logic             dout_finish,
    output logic [CNT_W-1:0] issued_blocks,
    output logic [CNT_W-1:0] finished_blocks,
    output logic [IFW-1:0]   in_flight,
    output logic             busy,
    output logic             done,
    output logic             underflow_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic             ctrl_valid_q, ctrl_valid_d;
    logic             status_ready_q;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] finished_q, finished_d;
    logic [IFW-1:0]   in_flight_q, in_flight_d;
    logic             underflow_q, underflow_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] target_q, target_d;

    logic ctrl_hs;
    logic status_hs;
    logic beat_pending;
    logic can_issue;

    always_comb begin
        ctrl_hs      = ctrl_valid_q && ctrl_ready;
        status_hs    = status_valid && status_ready_q;
        beat_pending = ctrl_valid_q && !ctrl_ready;

        state_d     = state_q;
        mode_d      = mode_q;
        target_d    = target_q;
        underflow_d = underflow_q;
        issued_d    = ctrl_hs ? issued_q + CNT_W'(1) : issued_q;
        finished_d  = status_hs ? finished_q + CNT_W'(1) : finished_q;
        in_flight_d = in_flight_q;

        // A handshake and a finish in the same cycle cancel out.
        if (ctrl_hs && !dout_finish) begin
            in_flight_d = in_flight_q + IFW'(1);
        end else if (!ctrl_hs && dout_finish) begin
            if (in_flight_q != '0) begin
                in_flight_d = in_flight_q - IFW'(1);
            end else begin
                underflow_d = 1'b1;
            end
        end

        can_issue = (state_q == StRun) && en && (in_flight_d < IFW'(MAX_IN_FLIGHT)) &&
                    (!mode_q || (issued_d < target_q)) && !beat_pending;
        // A raised beat is held until accepted, whatever the state does.
        ctrl_valid_d = beat_pending || can_issue;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StRun;
                    issued_d    = '0;
                    finished_d  = '0;
                    underflow_d = 1'b0;
                    mode_d      = mode;
                    target_d    = target_blocks;
                end
            end
            StRun: begin
                if (!en || (mode_q && (issued_d == target_q))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((in_flight_d == '0) && !ctrl_valid_d) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            ctrl_valid_q   <= 1'b0;
            status_ready_q <= 1'b0;
            issued_q       <= '0;
            finished_q     <= '0;
            in_flight_q    <= '0;
            underflow_q    <= 1'b0;
            mode_q         <= 1'b0;
            target_q       <= '0;
        end else begin
            state_q        <= state_d;
            ctrl_valid_q   <= ctrl_valid_d;
            status_ready_q <= 1'b1;
            issued_q       <= issued_d;
            finished_q     <= finished_d;
            in_flight_q    <= in_flight_d;
            underflow_q    <= underflow_d;
            mode_q         <= mode_d;
            target_q       <= target_d;
        end
    end

    assign ctrl_valid      = ctrl_valid_q;
    assign status_ready    = status_ready_q;
    assign issued_blocks   = issued_q;
    assign finished_blocks = finished_q;
    assign in_flight       = in_flight_q;
    assign underflow_err   = underflow_q;
    assign busy            = (state_q == StRun) || (state_q == StDrain);
    assign done            = (state_q == StDone);

endmodule
